nfa_class_seq_engine: RTL and testbench

Parametrised successor of the single-pattern NFA engines: matches an unanchored or line-anchored sequence of up to DEPTH character-class positions against a byte stream, one byte per enabled cycle. Class contents are runtime-loaded range tables rather than hard-coded compare blocks. Adds pulse/sticky output modes, case folding, a saturating match counter and first-match end offset. Sits in the engine array beside the generated engines and is driven by the same char/en/sod stream.

---
 rtl/nfa_class_seq_engine.sv | 113 +++++++++++
 tb/tb_nfa_class_seq_engine.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/nfa_class_seq_engine.sv
// Character-class sequence matcher: up to DEPTH positions, each a runtime-loaded
// table of RANGES inclusive byte ranges, evaluated one byte per enabled cycle.
module nfa_class_seq_engine #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned RANGES = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                                         clk,
    input  logic                                         sod,
    input  logic                                         en,
    input  logic [7:0]                                   char,
    input  logic                                         cfg_we,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0]   cfg_pos,
    input  logic [((RANGES > 1) ? $clog2(RANGES) : 1)-1:0] cfg_rng,
    input  logic [7:0]                                   cfg_lo,
    input  logic [7:0]                                   cfg_hi,
    input  logic [$clog2(DEPTH):0]                       cfg_len,
    input  logic                                         mode_sticky,
    input  logic                                         mode_anchor,
    input  logic                                         mode_nocase,
    output logic                                         out,
    output logic [CNT_W-1:0]                             match_count,
    output logic [CNT_W-1:0]                             match_end_pos,
    output logic                                         first_seen
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [7:0]       lo_q [DEPTH][RANGES];
    logic [7:0]       hi_q [DEPTH][RANGES];
    logic [DEPTH-1:0] s_q, s_d, cls;
    logic             prev_nl_q, start, is_letter, hit_sel, hit;
    logic [7:0]       alt_c;
    logic [LW-1:0]    len_eff;
    logic [CNT_W-1:0] byte_off_q, count_q, end_pos_q;
    logic             out_q, seen_q;

    // Range table has no reset and is untouched by sod.
    always_ff @(posedge clk) begin
        if (cfg_we && (32'(cfg_pos) < DEPTH) && (32'(cfg_rng) < RANGES)) begin
            lo_q[cfg_pos][cfg_rng] <= cfg_lo;
            hi_q[cfg_pos][cfg_rng] <= cfg_hi;
        end
    end

    always_comb begin
        is_letter = ((char >= 8'h41) && (char <= 8'h5A)) ||
                    ((char >= 8'h61) && (char <= 8'h7A));
        alt_c     = char ^ 8'h20;
        cls       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned r = 0; r < RANGES; r++) begin
                if ((lo_q[i][r] <= char) && (char <= hi_q[i][r]))
                    cls[i] = 1'b1;
                if (mode_nocase && is_letter &&
                    (lo_q[i][r] <= alt_c) && (alt_c <= hi_q[i][r]))
                    cls[i] = 1'b1;
            end
        end
    end

    // s_d[L-1] is exactly the "pattern of length L completes on this byte" term.
    always_comb begin
        start = mode_anchor ? prev_nl_q : 1'b1;
        s_d   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i == 0) s_d[i] = start & cls[i];
            else        s_d[i] = s_q[i-1] & cls[i];
        end

        if (cfg_len == '0)                len_eff = LW'(1);
        else if (cfg_len > LW'(DEPTH))    len_eff = LW'(DEPTH);
        else                              len_eff = cfg_len;

        hit_sel = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (32'(len_eff) == i + 1) hit_sel = s_d[i];
        end
        hit = en & hit_sel;
    end

    always_ff @(posedge clk) begin
        if (sod) begin
            s_q        <= '0;
            prev_nl_q  <= 1'b1;
            byte_off_q <= '0;
            out_q      <= 1'b0;
            count_q    <= '0;
            end_pos_q  <= '0;
            seen_q     <= 1'b0;
        end else begin
            if (en) begin
                s_q       <= s_d;
                prev_nl_q <= (char == 8'h0A);
                if (byte_off_q != '1) byte_off_q <= byte_off_q + CNT_W'(1);
            end
            out_q <= mode_sticky ? (out_q | hit) : hit;
            if (hit) begin
                if (count_q != '1) count_q <= count_q + CNT_W'(1);
                if (!seen_q) begin
                    end_pos_q <= byte_off_q;
                    seen_q    <= 1'b1;
                end
            end
        end
    end

    assign out           = out_q;
    assign match_count   = count_q;
    assign match_end_pos = end_pos_q;
    assign first_seen    = seen_q;

endmodule

// File: tb/tb_nfa_class_seq_engine.sv
// Directed bench for nfa_class_seq_engine: expected outputs are queued with each
// driven byte and checked one cycle later.
module tb_nfa_class_seq_engine;

    logic       clk;
    logic       sod, en, cfg_we;
    logic [7:0] char, cfg_lo, cfg_hi;
    logic [1:0] cfg_pos, cfg_rng;
    logic [2:0] cfg_len;
    logic       mode_sticky, mode_anchor, mode_nocase;
    logic       out, first_seen;
    logic [3:0] match_count, match_end_pos;

    typedef struct {
        logic       o;
        logic [3:0] cnt;
        logic       fs;
        logic [3:0] ep;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    nfa_class_seq_engine #(.DEPTH(4), .RANGES(3), .CNT_W(4)) dut (
        .clk(clk), .sod(sod), .en(en), .char(char),
        .cfg_we(cfg_we), .cfg_pos(cfg_pos), .cfg_rng(cfg_rng),
        .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_len(cfg_len),
        .mode_sticky(mode_sticky), .mode_anchor(mode_anchor), .mode_nocase(mode_nocase),
        .out(out), .match_count(match_count), .match_end_pos(match_end_pos),
        .first_seen(first_seen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] p, input logic [1:0] r,
                       input logic [7:0] lo, input logic [7:0] hi);
        en = 1'b0; sod = 1'b0;
        cfg_we = 1'b1; cfg_pos = p; cfg_rng = r; cfg_lo = lo; cfg_hi = hi;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic step(input string tag, input logic [7:0] c, input logic e,
                        input logic s, input logic eo, input int ecnt,
                        input logic efs, input int eep);
        exp_t x;
        x.o = eo; x.cnt = 4'(ecnt); x.fs = efs; x.ep = 4'(eep);
        sb.push_back(x);
        char = c; en = e; sod = s;
        @(posedge clk); #1;
        x = sb.pop_front();
        chk(tag, "out",   32'(out),           32'(x.o));
        chk(tag, "count", 32'(match_count),   32'(x.cnt));
        chk(tag, "seen",  32'(first_seen),    32'(x.fs));
        chk(tag, "end",   32'(match_end_pos), 32'(x.ep));
    endtask

    initial begin
        sod = 1'b1; en = 1'b0; char = '0; cfg_we = 1'b0;
        cfg_pos = '0; cfg_rng = '0; cfg_lo = '0; cfg_hi = '0;
        cfg_len = 3'd2; mode_sticky = 1'b1; mode_anchor = 1'b0; mode_nocase = 1'b0;

        for (int p = 0; p < 4; p++)
            for (int r = 0; r < 3; r++)
                cfg(2'(p), 2'(r), 8'hFF, 8'h00);
        cfg(2'd0, 2'd0, 8'h2D, 8'h2D);
        cfg(2'd1, 2'd0, 8'h30, 8'h39);
        cfg(2'd1, 2'd1, 8'h61, 8'h66);
        cfg(2'd1, 2'd2, 8'h41, 8'h46);

        // sticky, "x-7q"
        step("rst",    8'h00, 1, 1, 0, 0, 0, 0);
        step("st_x",   "x",   1, 0, 0, 0, 0, 0);
        step("st_-",   "-",   1, 0, 0, 0, 0, 0);
        step("st_7",   "7",   1, 0, 1, 1, 1, 2);
        step("st_q",   "q",   1, 0, 1, 1, 1, 2);

        // pulse, "-a-F-g"
        mode_sticky = 1'b0;
        step("p_sod",  8'h00, 1, 1, 0, 0, 0, 0);
        step("p_-0",   "-",   1, 0, 0, 0, 0, 0);
        step("p_a",    "a",   1, 0, 1, 1, 1, 1);
        step("p_-2",   "-",   1, 0, 0, 1, 1, 1);
        step("p_F",    "F",   1, 0, 1, 2, 1, 1);
        step("p_-4",   "-",   1, 0, 0, 2, 1, 1);
        step("p_g",    "g",   1, 0, 0, 2, 1, 1);

        // anchored, "z-1\n-2" then "-3" right after sod
        mode_anchor = 1'b1;
        step("a_sod",  8'h00, 1, 1, 0, 0, 0, 0);
        step("a_z",    "z",   1, 0, 0, 0, 0, 0);
        step("a_-1",   "-",   1, 0, 0, 0, 0, 0);
        step("a_1",    "1",   1, 0, 0, 0, 0, 0);
        step("a_nl",   8'h0A, 1, 0, 0, 0, 0, 0);
        step("a_-4",   "-",   1, 0, 0, 0, 0, 0);
        step("a_2",    "2",   1, 0, 1, 1, 1, 5);
        step("a_sod2", 8'h00, 1, 1, 0, 0, 0, 0);
        step("a_-0",   "-",   1, 0, 0, 0, 0, 0);
        step("a_3",    "3",   1, 0, 1, 1, 1, 1);
        mode_anchor = 1'b0;

        // case folding with pos1 = {61-66} only
        cfg(2'd1, 2'd0, 8'h61, 8'h66);
        cfg(2'd1, 2'd1, 8'hFF, 8'h00);
        cfg(2'd1, 2'd2, 8'hFF, 8'h00);
        mode_nocase = 1'b1;
        step("nc_sod", 8'h00, 1, 1, 0, 0, 0, 0);
        step("nc_-",   "-",   1, 0, 0, 0, 0, 0);
        step("nc_B",   "B",   1, 0, 1, 1, 1, 1);
        mode_nocase = 1'b0;
        step("cs_sod", 8'h00, 1, 1, 0, 0, 0, 0);
        step("cs_-",   "-",   1, 0, 0, 0, 0, 0);
        step("cs_B",   "B",   1, 0, 0, 0, 0, 0);

        // en gaps hold partial state; sod clears everything
        cfg(2'd1, 2'd0, 8'h30, 8'h39);
        step("g_sod",  8'h00, 1, 1, 0, 0, 0, 0);
        step("g_-",    "-",   1, 0, 0, 0, 0, 0);
        step("g_j0",   "5",   0, 0, 0, 0, 0, 0);
        step("g_j1",   "x",   0, 0, 0, 0, 0, 0);
        step("g_j2",   "-",   0, 0, 0, 0, 0, 0);
        step("g_5",    "5",   1, 0, 1, 1, 1, 1);
        step("g_idle", "5",   0, 0, 0, 1, 1, 1);
        step("g_clr",  "5",   1, 1, 0, 0, 0, 0);

        // cfg_len=0 acts as L=1; 20 matches saturate a 4-bit counter
        cfg_len = 3'd0;
        step("s_sod",  8'h00, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++)
            step("sat", "-", 1, 0, 1, (k + 1 > 15) ? 15 : k + 1, 1, 0);
        step("s_7",    "7",   1, 0, 0, 15, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
